// File: rtl/sync_fifo_ctl_if.sv
// Handshake and status bundle for sync_fifo_ctl.
// master drives requests, slave is the FIFO.
interface sync_fifo_ctl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  flush;
  logic                  wr_ena;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  wr_full;
  logic                  almost_full;
  logic                  rd_ena;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   dat_cnt;
  logic [ADDR_WIDTH:0]   peak_cnt;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output flush, wr_ena, wr_dat,
    output rd_ena, err_clr,
    input  wr_full, almost_full,
    input  rd_dat, rd_empty,
    input  almost_empty, dat_cnt,
    input  peak_cnt, overflow, underflow
  );

  modport slave (
    input  flush, wr_ena, wr_dat,
    input  rd_ena, err_clr,
    output wr_full, almost_full,
    output rd_dat, rd_empty,
    output almost_empty, dat_cnt,
    output peak_cnt, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctl.sv
// First-word-fall-through synchronous FIFO with thresholds,
// flush, sticky error flags and a peak-occupancy watermark.
module sync_fifo_ctl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int AFULL_TH   = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_ctl_if.slave f
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_C =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C =
    (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C =
    (ADDR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wrptr;
  logic [ADDR_WIDTH:0]   rdptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic [ADDR_WIDTH:0]   peak;
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ovf_q;
  logic                  unf_q;

  assign cnt   = wrptr - rdptr;
  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_C);

  assign rd_acc = f.rd_ena & ~empty & ~f.flush;
  // a pop in the same cycle frees the slot a full write needs
  assign wr_acc = f.wr_ena & ~f.flush & (~full | rd_acc);

  assign ovf_set = f.wr_ena & full & ~rd_acc & ~f.flush;
  assign unf_set = f.rd_ena & empty & ~f.flush;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !rd_acc)
      cnt_nxt = cnt + 1'b1;
    else if (rd_acc && !wr_acc)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrptr <= '0;
      rdptr <= '0;
      peak  <= '0;
    end else if (f.flush) begin
      wrptr <= '0;
      rdptr <= '0;
      peak  <= '0;
    end else begin
      if (wr_acc)
        wrptr <= wrptr + 1'b1;
      if (rd_acc)
        rdptr <= rdptr + 1'b1;
      if (cnt_nxt > peak)
        peak <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wrptr[ADDR_WIDTH-1:0]] <= f.wr_dat;
  end

  // set has priority over a same-cycle clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (f.err_clr)
        ovf_q <= 1'b0;
      if (unf_set)
        unf_q <= 1'b1;
      else if (f.err_clr)
        unf_q <= 1'b0;
    end
  end

  assign f.rd_dat       = mem[rdptr[ADDR_WIDTH-1:0]];
  assign f.rd_empty     = empty;
  assign f.wr_full      = full;
  assign f.almost_full  = (cnt >= AF_C);
  assign f.almost_empty = (cnt <= AE_C);
  assign f.dat_cnt      = cnt;
  assign f.peak_cnt     = peak;
  assign f.overflow     = ovf_q;
  assign f.underflow    = unf_q;
endmodule
